// File: rtl/sdr_div_pkg.sv
// Shared definitions for the SDR sequential signed divider.
//   state_e    : controller states (IDLE, CALC, FIX, DONE)
//   sat_max()  : most positive DW-bit two's complement value, zero-extended to 64 bits
//   sat_min()  : most negative DW-bit two's complement bit pattern, zero-extended to 64 bits
//   cnt_width(): bit-counter width needed to hold DW-1
package sdr_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic [63:0] sat_max(input int unsigned dw);
    return (64'd1 << (dw - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned dw);
    return 64'd1 << (dw - 1);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned dw);
    return $clog2(dw);
  endfunction

endpackage

// File: rtl/sdr_div_step.sv
// One combinational radix-2 restoring division step.
//   i_rem  : partial remainder (always < |divisor|, so VW bits suffice)
//   i_bit  : next dividend bit, MSB first
//   i_dabs : divisor magnitude
//   o_rem  : updated partial remainder
//   o_qbit : quotient bit (1 when the trial subtraction did not borrow)
module sdr_div_step #(
  parameter int unsigned VW = 10
) (
  input  logic [VW-1:0] i_rem,
  input  logic          i_bit,
  input  logic [VW-1:0] i_dabs,
  output logic [VW-1:0] o_rem,
  output logic          o_qbit
);

  // Shifted partial remainder needs one extra bit before the trial subtract.
  logic [VW:0] w_shift;
  logic        w_ge;

  assign w_shift = {i_rem, i_bit};
  assign w_ge    = (w_shift >= {1'b0, i_dabs});
  assign o_qbit  = w_ge;
  // Whichever branch is taken the result is below |divisor|, so the top bit is always 0.
  assign o_rem   = w_ge ? VW'(w_shift - {1'b0, i_dabs}) : w_shift[VW-1:0];

endmodule

// File: rtl/sdr_seq_divider.sv
// Sequential signed divider (truncating toward zero), radix-2 restoring.
//   clk, reset_n : rising-edge clock, asynchronous active-low reset
//   ce           : clock enable; 0 freezes every register
//   start        : request, accepted in IDLE only
//   dividend     : DW-bit signed dividend, captured with start
//   divisor      : VW-bit signed divisor, captured with start
//   busy         : high from the cycle after an accepted start through the valid cycle
//   valid        : one-cycle result strobe
//   quotient     : DW-bit signed quotient, held until next valid
//   remainder    : VW-bit signed remainder, sign follows dividend
//   div_zero     : divisor was zero (quotient saturated by dividend sign)
//   ovf          : most-negative / -1 overflow (quotient saturated positive)
module sdr_seq_divider
  import sdr_div_pkg::*;
#(
  parameter int unsigned DW = 20,
  parameter int unsigned VW = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic                 start,
  input  logic signed [DW-1:0] dividend,
  input  logic signed [VW-1:0] divisor,
  output logic                 busy,
  output logic                 valid,
  output logic signed [DW-1:0] quotient,
  output logic signed [VW-1:0] remainder,
  output logic                 div_zero,
  output logic                 ovf
);

  localparam int unsigned   CW    = cnt_width(DW);
  localparam logic [DW-1:0] Q_MAX = DW'(sat_max(DW));
  localparam logic [DW-1:0] Q_MIN = DW'(sat_min(DW));

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_q;        // dividend magnitude shifting out, quotient bits shifting in
  logic [VW-1:0] r_rem;
  logic [VW-1:0] r_dabs;
  logic          r_dvd_neg;
  logic          r_dsr_neg;
  logic          r_dz;
  logic          r_ovf;

  logic [DW-1:0] w_dvd_abs;
  logic [VW-1:0] w_dsr_abs;
  logic          w_is_dz;
  logic          w_is_ovf;
  logic [VW-1:0] w_rem_nxt;
  logic          w_qbit;
  logic [DW-1:0] w_q_neg;
  logic [VW-1:0] w_r_neg;

  // Magnitudes are kept unsigned, so |-2^(DW-1)| = 2^(DW-1) is exact in DW bits.
  assign w_dvd_abs = dividend[DW-1] ? ('0 - dividend) : dividend;
  assign w_dsr_abs = divisor[VW-1]  ? ('0 - divisor)  : divisor;
  assign w_is_dz   = (divisor == '0);
  assign w_is_ovf  = (dividend == Q_MIN) && (divisor == '1);
  assign w_q_neg   = '0 - r_q;
  assign w_r_neg   = '0 - r_rem;

  assign busy  = (r_state != S_IDLE);
  assign valid = (r_state == S_DONE);

  sdr_div_step #(
    .VW(VW)
  ) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_q[DW-1]),
    .i_dabs (r_dabs),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_q       <= '0;
      r_rem     <= '0;
      r_dabs    <= '0;
      r_dvd_neg <= 1'b0;
      r_dsr_neg <= 1'b0;
      r_dz      <= 1'b0;
      r_ovf     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else if (ce) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_q       <= w_dvd_abs;
            r_rem     <= '0;
            r_dabs    <= w_dsr_abs;
            r_dvd_neg <= dividend[DW-1];
            r_dsr_neg <= divisor[VW-1];
            r_dz      <= w_is_dz;
            r_ovf     <= w_is_ovf;
            r_cnt     <= CW'(DW - 1);
            r_state   <= (w_is_dz || w_is_ovf) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nxt;
          r_q   <= {r_q[DW-2:0], w_qbit};
          if (r_cnt == '0) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_FIX: begin
          if (r_dz) begin
            quotient  <= r_dvd_neg ? Q_MIN : Q_MAX;
            remainder <= '0;
            div_zero  <= 1'b1;
            ovf       <= 1'b0;
          end else if (r_ovf) begin
            quotient  <= Q_MAX;
            remainder <= '0;
            div_zero  <= 1'b0;
            ovf       <= 1'b1;
          end else begin
            quotient  <= (r_dvd_neg ^ r_dsr_neg) ? w_q_neg : r_q;
            remainder <= r_dvd_neg ? w_r_neg : r_rem;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_seq_divider.sv
// Directed self-checking bench for sdr_seq_divider.
module tb_sdr_seq_divider;

  localparam int DW = 20;
  localparam int VW = 10;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 ce;
  logic                 start;
  logic signed [DW-1:0] dividend;
  logic signed [VW-1:0] divisor;
  logic                 busy;
  logic                 valid;
  logic signed [DW-1:0] quotient;
  logic signed [VW-1:0] remainder;
  logic                 div_zero;
  logic                 ovf;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int dvd;
    int dsr;
    int lat;
    int q;
    int r;
    int dz;
    int ov;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  sdr_seq_divider #(
    .DW(DW),
    .VW(VW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .valid     (valid),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outputs_reset(input string tag);
    chk({tag, "_busy_valid"}, longint'({busy, valid}), 0);
    chk({tag, "_flags"}, longint'({div_zero, ovf}), 0);
    chk({tag, "_quotient"}, longint'(quotient), 0);
    chk({tag, "_remainder"}, longint'(remainder), 0);
  endtask

  // Start one operation at cycle T and follow it to the valid cycle.
  task automatic run_op(input string tag, input int dvd, input int dsr, input int lat,
                        input int q, input int r, input int dz, input int ov);
    int k_valid = -1;
    int busy_ok = 1;
    @(negedge clk);
    dividend = dvd[DW-1:0];
    divisor  = dsr[VW-1:0];
    start    = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (!busy) busy_ok = 0;
      if (valid) begin
        k_valid = k;
        break;
      end
    end
    chk({tag, "_latency"}, k_valid, lat);
    chk({tag, "_busy"}, busy_ok, 1);
    chk({tag, "_quotient"}, longint'(quotient), q);
    chk({tag, "_remainder"}, longint'(remainder), r);
    chk({tag, "_div_zero"}, longint'(div_zero), dz);
    chk({tag, "_ovf"}, longint'(ovf), ov);
    @(negedge clk);
    chk({tag, "_idle_after"}, longint'({busy, valid}), 0);
  endtask

  initial begin
    int first_valid;
    int n_valid;
    int busy_ok;

    vecs.push_back('{1000,     7,    22,  142,     6,  0, 0});
    vecs.push_back('{-1000,    7,    22, -142,    -6,  0, 0});
    vecs.push_back('{524287,  -512,  22, -1023,   511, 0, 0});
    vecs.push_back('{5,        0,     2,  524287,  0,  1, 0});
    vecs.push_back('{-5,       0,     2, -524288,  0,  1, 0});
    vecs.push_back('{-524288, -1,     2,  524287,  0,  0, 1});
    vecs.push_back('{100,      10,   22,  10,      0,  0, 0});
    vecs.push_back('{-7,       2,    22, -3,      -1,  0, 0});
    vecs.push_back('{7,       -2,    22, -3,       1,  0, 0});
    vecs.push_back('{-524288,  1,    22, -524288,  0,  0, 0});
    vecs.push_back('{-524288, -512,  22,  1024,    0,  0, 0});
    vecs.push_back('{-524288,  3,    22, -174762, -2,  0, 0});
    vecs.push_back('{0,        5,    22,  0,       0,  0, 0});

    reset_n  = 1'b0;
    ce       = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk_outputs_reset("reset");
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dsr, vecs[i].lat,
             vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov);
    end

    // 1000/7 with a 5-cycle ce stall mid-CALC and a stray start while busy.
    first_valid = -1;
    n_valid     = 0;
    busy_ok     = 1;
    @(negedge clk);
    dividend = 20'sd1000;
    divisor  = 10'sd7;
    start    = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (valid) begin
        n_valid++;
        if (first_valid < 0) first_valid = k;
      end
      if (k <= 27 && !busy) busy_ok = 0;
      if (k == 4) begin
        dividend = -20'sd3;
        divisor  = 10'sd1;
      end
      start = (k == 4);
      ce    = !(k >= 8 && k <= 12);
    end
    ce = 1'b1;
    chk("stall_latency", first_valid, 27);
    chk("stall_valid_count", n_valid, 1);
    chk("stall_busy", busy_ok, 1);
    chk("stall_quotient", longint'(quotient), 142);
    chk("stall_remainder", longint'(remainder), 6);

    // Reset asserted mid-operation.
    @(negedge clk);
    dividend = 20'sd1000;
    divisor  = 10'sd7;
    start    = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort_busy_before", longint'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk_outputs_reset("abort");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n_valid = 0;
    busy_ok = 1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (valid) n_valid++;
      if (busy) busy_ok = 0;
    end
    chk("abort_no_valid", n_valid, 0);
    chk("abort_stays_idle", busy_ok, 1);

    run_op("post_abort", 9, -2, 22, -4, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdr_seq_divider.md
Name: sdr_seq_divider

Overview:
Sequential signed integer divider for the SDR peripheral datapath. It is the inverse of the registered 10x10 signed multiplier: it takes a 20-bit signed product-width dividend and a 10-bit signed divisor. Typical uses are AGC gain normalisation and mixer amplitude rescaling. It is a radix-2 restoring divider with start/busy/valid handshake and clock enable; quotient truncates toward zero.

Parameters:
DW, 20, dividend and quotient width (signed, two's complement)
VW, 10, divisor and remainder width (signed, two's complement); VW <= DW

Ports:
clk  in  1  system clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
ce  in  1  clock enable; 0 freezes every register including valid
start  in  1  request; sampled in IDLE when ce=1
dividend  in  DW  signed dividend, captured with start
divisor  in  VW  signed divisor, captured with start
busy  out  1  high from cycle after accepted start until valid cycle inclusive
valid  out  1  result-valid pulse, one ce-qualified cycle
quotient  out  DW  signed quotient, held until next valid
remainder  out  VW  signed remainder, sign follows dividend, held until next valid
div_zero  out  1  divisor was 0, updated with valid
ovf  out  1  quotient saturated, updated with valid

Behaviour:
- Reset (async assert, sync release): state=IDLE. busy, valid, quotient, remainder, div_zero, ovf all 0. Operand registers cleared.
- All cycle counts below are ce=1 cycles; ce=0 cycles insert stalls with no state change.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 in cycle T: capture operands, |dividend|, |divisor|, and the sign flags.
  - Divisor=0 or (dividend=-2^(DW-1) and divisor=-1): go to FIX (special path).
  - Otherwise: go to CALC, with bit counter = DW-1.
- CALC: one restoring step per cycle, MSB first. Partial remainder is VW+1 bits unsigned; shift in the next dividend bit; subtract |divisor| if the result is non-negative; quotient bit = not borrow. Counter decrements; at 0 go to FIX. CALC takes exactly DW cycles (T+1..T+DW).
- FIX: apply signs. Quotient is negated if the sign flags differ. Remainder is negated if the dividend is negative. Then go to DONE.
- Special path in FIX:
  - div_zero: quotient = +2^(DW-1)-1 if dividend>=0, else -2^(DW-1). remainder=0, div_zero=1.
  - Overflow case: quotient = +2^(DW-1)-1, remainder=0, ovf=1.
- DONE: outputs registered; valid=1 for this cycle; return to IDLE.
- Latency (normal): valid at T+DW+2 (T+22 at default).
- Latency (special): valid at T+2.
- busy is 1 from T+1 through the valid cycle.
- start while busy=1 is ignored and not queued.
- start in the valid cycle is ignored; a new start is accepted from the next IDLE cycle (T+DW+3) at the earliest.
- div_zero and ovf clear to 0 on a normal-path valid.
- Magnitude of -2^(DW-1) is DW+1 bits internally; no wrap.
- |remainder| < |divisor| always, so it fits in VW bits.
- reset_n low mid-operation aborts immediately. No valid is produced. The bench sees all outputs at reset values.

Decomposition:
- Package sdr_div_pkg:
  - state enum (IDLE, CALC, FIX, DONE)
  - localparam functions for the max/min saturation constants given DW
  - counter width = clog2(DW)
- Sub-module sdr_div_step (combinational single restoring step):
  - inputs: partial remainder, next dividend bit, |divisor|
  - outputs: new remainder, quotient bit
  - instantiated once, in the CALC datapath.

Test Plan:
- 1000 / 7, start at T, ce=1 -> valid at T+22, quotient=142, remainder=6, busy high T+1..T+22, div_zero=ovf=0.
- -1000 / 7 -> quotient=-142, remainder=-6. Then 524287 / -512 -> quotient=-1023, remainder=511.
- 5 / 0 -> valid at T+2, quotient=524287, remainder=0, div_zero=1. Then -5 / 0 -> quotient=-524288, div_zero=1.
- -524288 / -1 -> valid at T+2, quotient=524287, ovf=1. Next normal op 100/10 -> quotient=10, remainder=0, ovf=0.
- 1000 / 7 with ce=0 for 5 cycles mid-CALC, plus start pulsed at T+4 -> valid at T+27, result 142/6, second start ignored (exactly one valid).
- reset_n low at T+10 of an operation -> busy=valid=0 immediately, no valid after release. A fresh 9/-2 -> quotient=-4, remainder=1.
